// File: rtl/rot_seq_pkg.sv
// Shared definitions for the rotate/shift self-test sequencer.
//   - FSM state encodings
//   - mode encodings (sweep / LFSR)
//   - LFSR seed and tap positions
//   - golden rotate functions, written for any width up to GOLD_MAX_W
package rot_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } rot_seq_state_e;

  localparam logic MODE_SWEEP = 1'b0;
  localparam logic MODE_LFSR  = 1'b1;

  // x^5 + x^3 + 1, Fibonacci form: next = {q[3:0], q[4] ^ q[2]}
  localparam logic [4:0] LFSR_SEED   = 5'b00001;
  localparam int         LFSR_TAP_HI = 4;
  localparam int         LFSR_TAP_LO = 2;

  localparam int GOLD_MAX_W = 64;

  // {d,d} built at width w, then shifted; a shift of 0 returns d for both
  // directions without ever shifting a w-bit value by w.
  function automatic logic [2*GOLD_MAX_W-1:0] gold_dup(
    input logic [GOLD_MAX_W-1:0] d,
    input int unsigned           w
  );
    logic [2*GOLD_MAX_W-1:0] dd;
    dd = ({{GOLD_MAX_W{1'b0}}, d} << w) | {{GOLD_MAX_W{1'b0}}, d};
    return dd;
  endfunction

  function automatic logic [GOLD_MAX_W-1:0] gold_mask(input int unsigned w);
    logic [2*GOLD_MAX_W-1:0] m;
    m = ({{(2*GOLD_MAX_W-1){1'b0}}, 1'b1} << w) - 1;
    return m[GOLD_MAX_W-1:0];
  endfunction

  function automatic logic [GOLD_MAX_W-1:0] gold_rotl(
    input logic [GOLD_MAX_W-1:0] d,
    input int unsigned           s,
    input int unsigned           w
  );
    logic [2*GOLD_MAX_W-1:0] r;
    r = gold_dup(d, w) >> (w - s);
    return r[GOLD_MAX_W-1:0] & gold_mask(w);
  endfunction

  function automatic logic [GOLD_MAX_W-1:0] gold_rotr(
    input logic [GOLD_MAX_W-1:0] d,
    input int unsigned           s,
    input int unsigned           w
  );
    logic [2*GOLD_MAX_W-1:0] r;
    r = gold_dup(d, w) >> s;
    return r[GOLD_MAX_W-1:0] & gold_mask(w);
  endfunction

endpackage

// File: rtl/rot_seq_lfsr5.sv
// 5-bit Fibonacci LFSR (x^5 + x^3 + 1) supplying pseudo-random shift amounts.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset, loads LFSR_SEED
//   advance step to the next state this cycle
//   state   current LFSR value (never 0)
import rot_seq_pkg::*;

module rot_seq_lfsr5 (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [4:0] state
);

  logic feedback;
  assign feedback = state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       state <= LFSR_SEED;
    else if (advance) state <= {state[3:0], feedback};
  end

endmodule

// File: rtl/rotate_shift_sequencer.sv
// Self-checking stimulus sequencer for a barrel rotator.
// Issues (data, shift) pairs, waits RESULT_LAT clocks, then checks the
// rotator's left/right results against a golden rotate.
// Optional build macro: STOP_ON_FAIL_EN -- first mismatch ends the run.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   start, mode          run request (IDLE only), 0 sweep / 1 LFSR shifts
//   seed_data            first operand, num_vectors run length
//   rot_data, rot_shift  registered operands to the rotator
//   left_rotate, right_rotate  rotator results
//   busy, done           run in progress, one-cycle end-of-run pulse
//   vec_count, err_count vectors checked, mismatching vectors (saturating)
//   first_fail_valid/_shift  shift amount of the first mismatching vector
import rot_seq_pkg::*;

module rotate_shift_sequencer #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_W    = 5,
  parameter int COUNT_W    = 8,
  parameter int RESULT_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   seed_data,
  input  logic [COUNT_W-1:0] num_vectors,
  output logic [WIDTH-1:0]   rot_data,
  output logic [SHIFT_W-1:0] rot_shift,
  input  logic [WIDTH-1:0]   left_rotate,
  input  logic [WIDTH-1:0]   right_rotate,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] vec_count,
  output logic [COUNT_W-1:0] err_count,
  output logic               first_fail_valid,
  output logic [SHIFT_W-1:0] first_fail_shift
);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_ISSUE = 3'(ISSUE);
  localparam logic [2:0] S_WAIT  = 3'(WAIT);
  localparam logic [2:0] S_CHECK = 3'(CHECK);
  localparam logic [2:0] S_DONE  = 3'(DONE);

  localparam int LAT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'((RESULT_LAT > 0) ? RESULT_LAT - 1 : 0);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(WIDTH - 1);

  logic [2:0]         state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [COUNT_W-1:0] num_q;
  logic               mode_q;
  logic [4:0]         lfsr_state;

  // golden results for the vector currently on rot_data/rot_shift
  logic [WIDTH-1:0] rotl_exp, rotr_exp;
  assign rotl_exp = WIDTH'(gold_rotl(GOLD_MAX_W'(rot_data), 32'(rot_shift), WIDTH));
  assign rotr_exp = WIDTH'(gold_rotr(GOLD_MAX_W'(rot_data), 32'(rot_shift), WIDTH));

  logic mismatch;
  assign mismatch = (left_rotate != rotl_exp) || (right_rotate != rotr_exp);

  logic [COUNT_W-1:0] vec_next;
  logic               last_vec, stop_now;
  assign vec_next = vec_count + COUNT_W'(1);
  assign last_vec = (vec_next == num_q);
`ifdef STOP_ON_FAIL_EN
  assign stop_now = last_vec || mismatch;
`else
  assign stop_now = last_vec;
`endif

  // The LFSR steps exactly when its value is consumed into rot_shift, so the
  // sequence continues across runs.
  logic load_first, load_next, lfsr_adv;
  assign load_first = (state == S_IDLE) && start && (num_vectors != '0);
  assign load_next  = (state == S_CHECK) && !stop_now;
  assign lfsr_adv   = (load_first && (mode == MODE_LFSR)) ||
                      (load_next && (mode_q == MODE_LFSR));

  rot_seq_lfsr5 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  assign busy = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      lat_cnt          <= '0;
      num_q            <= '0;
      mode_q           <= MODE_SWEEP;
      rot_data         <= '0;
      rot_shift        <= '0;
      vec_count        <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_shift <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_q            <= num_vectors;
            mode_q           <= mode;
            vec_count        <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_shift <= '0;
            if (num_vectors == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_ISSUE;
              rot_data  <= seed_data;
              rot_shift <= (mode == MODE_LFSR) ? SHIFT_W'(lfsr_state) : '0;
            end
          end
        end
        S_ISSUE: begin
          if (RESULT_LAT == 0) begin
            state <= S_CHECK;
          end else begin
            state   <= S_WAIT;
            lat_cnt <= LAT_INIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) state <= S_CHECK;
          else               lat_cnt <= lat_cnt - LAT_W'(1);
        end
        S_CHECK: begin
          vec_count <= vec_next;
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + COUNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_shift <= rot_shift;
            end
          end
          if (stop_now) begin
            state <= S_DONE;
          end else begin
            state <= S_ISSUE;
            if (mode_q == MODE_LFSR) begin
              rot_shift <= SHIFT_W'(lfsr_state);
            end else begin
              rot_shift <= rot_shift + SHIFT_W'(1);
              // each full sweep of shifts moves the data pattern by one bit
              if (rot_shift == SHIFT_MAX)
                rot_data <= {rot_data[WIDTH-2:0], rot_data[WIDTH-1]};
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_shift_sequencer.sv
module tb_rotate_shift_sequencer;

  localparam int LAT = 1;
  localparam int PER = LAT + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] seed_data = '0;
  logic [7:0]  num_vectors = '0;
  logic [31:0] rot_data;
  logic [4:0]  rot_shift;
  logic [31:0] left_rotate, right_rotate;
  logic        busy, done;
  logic [7:0]  vec_count, err_count;
  logic        first_fail_valid;
  logic [4:0]  first_fail_shift;

  int n_cmp = 0;
  int n_err = 0;
  int fault = 0;  // 0 good rotator, 1 left bit0 stuck at 0, 2 left inverted

  typedef struct {
    logic [4:0]  shift;
    logic [31:0] data;
  } vec_t;
  vec_t sb[$];

  always #5 clk = ~clk;

  rotate_shift_sequencer #(
    .WIDTH(32), .SHIFT_W(5), .COUNT_W(8), .RESULT_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .seed_data(seed_data), .num_vectors(num_vectors),
    .rot_data(rot_data), .rot_shift(rot_shift),
    .left_rotate(left_rotate), .right_rotate(right_rotate),
    .busy(busy), .done(done), .vec_count(vec_count), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_shift(first_fail_shift)
  );

  function automatic logic [31:0] ref_rotl(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] t;
    t = {d, d} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] ref_rotr(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] t;
    t = {d, d} >> s;
    return t[31:0];
  endfunction

  // reference rotator, one register stage, with optional planted fault
  always @(posedge clk) begin
    case (fault)
      1:       left_rotate <= ref_rotl(rot_data, rot_shift) & ~32'd1;
      2:       left_rotate <= ~ref_rotl(rot_data, rot_shift);
      default: left_rotate <= ref_rotl(rot_data, rot_shift);
    endcase
    right_rotate <= ref_rotr(rot_data, rot_shift);
  end

  task automatic push_sweep(input logic [31:0] seed, input int num);
    logic [31:0] d;
    vec_t e;
    d = seed;
    for (int v = 0; v < num; v++) begin
      e.shift = 5'(v % 32);
      e.data  = d;
      sb.push_back(e);
      if (v % 32 == 31) d = {d[30:0], d[31]};
    end
  endtask

  // Drives one run; expected vectors must already be in sb.
  task automatic run_vectors(input string name, input logic [31:0] seed, input int num,
                             input logic md, input int exp_vec, input int exp_err,
                             input logic exp_ffv, input logic [4:0] exp_ffs,
                             input int pulse_at);
    int   k, done_at, limit;
    bit   seen, busy_seen;
    vec_t e;
    seen = 0; busy_seen = 0; done_at = 0;
    limit = exp_vec * PER + 20;
    @(negedge clk);
    seed_data = seed; num_vectors = 8'(num); mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 1;
    while (!seen && k <= limit) begin
      if (done === 1'b1) begin
        seen = 1; done_at = k;
      end else begin
        if (busy === 1'b1) busy_seen = 1;
        if ((k - 1) % PER == 0 && (k - 1) / PER < exp_vec && sb.size() > 0) begin
          e = sb.pop_front();
          n_cmp++;
          if (rot_shift !== e.shift || rot_data !== e.data) begin
            n_err++;
            $display("FAIL %s vec%0d: got shift=%0d data=%h want shift=%0d data=%h",
                     name, (k - 1) / PER, rot_shift, rot_data, e.shift, e.data);
          end
        end
        if (k == pulse_at) begin
          start = 1'b1; seed_data = 32'hFFFF0000; num_vectors = 8'd3; mode = ~md;
        end else begin
          start = 1'b0;
        end
        @(negedge clk); k++;
      end
    end
    start = 1'b0;
    sb.delete();
    n_cmp++;
    if (!seen || done_at != exp_vec * PER + 1) begin
      n_err++;
      $display("FAIL %s done_time: got %0d (seen=%0d) want %0d", name, done_at, seen,
               exp_vec * PER + 1);
    end
    n_cmp++;
    if (busy_seen != (num != 0)) begin
      n_err++;
      $display("FAIL %s busy_seen: got %0d want %0d", name, busy_seen, num != 0);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
    end
    n_cmp++;
    if (vec_count !== 8'(exp_vec) || err_count !== 8'(exp_err)) begin
      n_err++;
      $display("FAIL %s counts: got vec=%0d err=%0d want vec=%0d err=%0d",
               name, vec_count, err_count, exp_vec, exp_err);
    end
    n_cmp++;
    if (first_fail_valid !== exp_ffv || (exp_ffv && first_fail_shift !== exp_ffs)) begin
      n_err++;
      $display("FAIL %s first_fail: got v=%b s=%0d want v=%b s=%0d",
               name, first_fail_valid, first_fail_shift, exp_ffv, exp_ffs);
    end
  endtask

  task automatic test_reset();
    int dn;
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, rot_data, rot_shift, vec_count, err_count, first_fail_valid,
         first_fail_shift} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b data=%h shift=%0d vec=%0d err=%0d ffv=%b want all 0",
               busy, done, rot_data, rot_shift, vec_count, err_count, first_fail_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    seed_data = 32'h1; num_vectors = 8'd40; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10 * PER) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rot_shift !== 5'd10) begin
      n_err++;
      $display("FAIL reset_midrun_pre: got busy=%b shift=%0d want 1 10", busy, rot_shift);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || rot_shift !== 5'd0 || err_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_midrun: got busy=%b done=%b shift=%0d err=%0d want 0 0 0 0",
               busy, done, rot_shift, err_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (150) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    n_cmp++;
    if (dn != 0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", dn);
    end
  endtask

  task automatic test_sweep();
    fault = 0;
    push_sweep(32'h1, 40);
    run_vectors("sweep", 32'h1, 40, 1'b0, 40, 0, 1'b0, 5'd0, 0);
  endtask

  task automatic test_zero();
    fault = 0;
    run_vectors("zero", 32'h1234_5678, 0, 1'b0, 0, 0, 1'b0, 5'd0, 0);
  endtask

  task automatic test_fault();
    fault = 1;
    push_sweep(32'h1, 32);
`ifdef STOP_ON_FAIL_EN
    run_vectors("fault", 32'h1, 32, 1'b0, 1, 1, 1'b1, 5'd0, 0);
`else
    run_vectors("fault", 32'h1, 32, 1'b0, 32, 1, 1'b1, 5'd0, 0);
`endif
    fault = 0;
  endtask

  task automatic test_lfsr();
    logic [4:0] seq [5];
    vec_t e;
    seq = '{5'd1, 5'd2, 5'd4, 5'd9, 5'd18};
    fault = 0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.shift = seq[i]; e.data = 32'hC3A5_0F01;
      sb.push_back(e);
    end
    run_vectors("lfsr", 32'hC3A5_0F01, 5, 1'b1, 5, 0, 1'b0, 5'd0, 0);
  endtask

  task automatic test_back_to_back();
    fault = 2;
    push_sweep(32'hA5A5_0F0F, 255);
`ifdef STOP_ON_FAIL_EN
    run_vectors("saturate", 32'hA5A5_0F0F, 255, 1'b0, 1, 1, 1'b1, 5'd0, 2);
`else
    run_vectors("saturate", 32'hA5A5_0F0F, 255, 1'b0, 255, 255, 1'b1, 5'd0, 50);
`endif
    fault = 0;
    // the following run must start cleanly after the saturated one
    push_sweep(32'h8000_0001, 3);
    run_vectors("after_sat", 32'h8000_0001, 3, 1'b0, 3, 0, 1'b0, 5'd0, 0);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_zero();
    test_fault();
    test_lfsr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
